alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Command-side initiator for the registered 16-bit ALU.
- Accepts one operation per valid/ready handshake, drives A, B and ALU_FUN into the ALU for one cycle, then captures ALU_OUT and the four class flags on the following cycle.
- Checks the captured flags against the opcode class and returns result, flags and error status on a valid/ready response channel.
- Sits between the datapath controller and the ALU instance.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_FUN  in  4  opcode, same encoding as ALU_FUN.
- CMD_A  in  WIDTH  operand A.
- CMD_B  in  WIDTH  operand B.
- ALU_A  out  WIDTH  to ALU A.
- ALU_B  out  WIDTH  to ALU B.
- ALU_FUN  out  4  to ALU ALU_FUN.
- ALU_OUT  in  WIDTH  from ALU (registered result).
- ALU_FLAGS  in  4  {Arith_Flag, Logic_Flag, Cmp_Flag, Shift_Flag} from ALU.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DATA  out  WIDTH  captured result.
- RSP_FLAGS  out  4  captured flags, same bit order as ALU_FLAGS.
- RSP_ERR  out  1  divide-by-zero or flag/class mismatch.
- OP_COUNT  out  CNT_W  number of responses consumed.

Behaviour:
- One clock (CLK). RST is asynchronous and active-low. While RST=0:
  - state=IDLE.
  - RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR, OP_COUNT = 0.
  - ALU_A and ALU_B = 0; ALU_FUN = 4'b1111.
  - CMD_READY = 1.
- A reset mid-operation drops the in-flight command; no response is produced.
- CMD_READY = (state==IDLE), combinational. A command is accepted on a CLK edge where CMD_VALID & CMD_READY. Accepting latches CMD_FUN, CMD_A and CMD_B into internal registers.
- FSM:
  - IDLE --accept, not div0--> ISSUE.
  - IDLE --accept, CMD_FUN==4'b0011 and CMD_B==0--> RESP, with RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=1. The ALU is never driven for this command.
  - ISSUE (1 cycle): ALU_A, ALU_B and ALU_FUN are driven from the latched command. The ALU registers the result at the edge that ends ISSUE. Next state: CAPTURE.
  - CAPTURE (1 cycle): ALU_FUN = 4'b1111. At the edge that ends CAPTURE, RSP_DATA <= ALU_OUT and RSP_FLAGS <= ALU_FLAGS, and RSP_ERR is computed (rule below). Next state: RESP.
  - RESP: RSP_VALID=1. All RSP_* outputs are held stable until RSP_READY=1 at a CLK edge. On that edge: RSP_VALID <= 0, OP_COUNT increments (wraps modulo 2^CNT_W), next state IDLE.
- Outside ISSUE, ALU_FUN = 4'b1111. ALU_A and ALU_B hold their last values.
- No command is accepted in the same cycle a response is consumed. Maximum throughput is 1 operation per 4 cycles.
- Latency, measured from the accept edge to the edge at which RSP_VALID is first seen high:
  - normal op: 3 cycles;
  - div-by-zero: 1 cycle.
- Expected flag class for RSP_ERR:
  - 0000–0011 → 4'b1000;
  - 0100–1001 → 4'b0100;
  - 1010–1100 → 4'b0010;
  - 1101–1110 → 4'b0001;
  - 1111 → 4'b0000.
- RSP_ERR=1 iff captured ALU_FLAGS != expected class. RSP_DATA is still delivered in that case.
- CMD_* inputs are ignored outside IDLE.
- A RSP_READY held high in advance is legal; the response is consumed on the first RESP cycle.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (FUN_ADD…FUN_SHL, FUN_NOP=4'b1111);
  - flag bit positions;
  - FSM state encoding (IDLE, ISSUE, CAPTURE, RESP);
  - class-decode function opcode→expected 4-bit flags.
- One sub-module, alu_flag_checker: combinational opcode + flags → err. It is reused by the ALU testbench scoreboard.
- The FSM and registers stay in alu_sequencer.

Test Plan:
- ADD, A=16'h0003, B=16'h0004, RSP_READY=1 → RSP_VALID 3 cycles after accept; RSP_DATA=16'h0007, RSP_FLAGS=4'b1000, RSP_ERR=0, OP_COUNT=1.
- DIV, A=16'h0010, B=0 → RSP_VALID 1 cycle after accept; RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=1; ALU_FUN stays 4'b1111 throughout.
- CMP_GT, A=16'h0009, B=16'h0002, RSP_READY low for 5 cycles → RSP_DATA=16'h0002 and RSP_FLAGS=4'b0010 held stable; CMD_READY=0 and OP_COUNT unchanged until RSP_READY rises.
- ALU model forced to return flags 4'b0100 for a SHL command → RSP_ERR=1, RSP_DATA still captured from ALU_OUT.
- Opcode 4'b1111, A=B=16'hFFFF → RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=0.
- RST pulsed low during ISSUE → all outputs at reset values immediately, no response afterward, CMD_READY=1.
- With CNT_W=2, 5 back-to-back XOR commands → OP_COUNT sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its command sequencer.
// Contents:
//   - opcode encodings, identical to the ALU's ALU_FUN input
//   - bit positions inside the 4-bit class flag vector
//   - sequencer FSM state encoding
//   - expected_flags(): opcode -> the single class flag the ALU should raise
package alu_pkg;

    localparam logic [3:0] FUN_ADD    = 4'b0000;
    localparam logic [3:0] FUN_SUB    = 4'b0001;
    localparam logic [3:0] FUN_MUL    = 4'b0010;
    localparam logic [3:0] FUN_DIV    = 4'b0011;
    localparam logic [3:0] FUN_AND    = 4'b0100;
    localparam logic [3:0] FUN_OR     = 4'b0101;
    localparam logic [3:0] FUN_NAND   = 4'b0110;
    localparam logic [3:0] FUN_NOR    = 4'b0111;
    localparam logic [3:0] FUN_XOR    = 4'b1000;
    localparam logic [3:0] FUN_XNOR   = 4'b1001;
    localparam logic [3:0] FUN_CMP_EQ = 4'b1010;
    localparam logic [3:0] FUN_CMP_GT = 4'b1011;
    localparam logic [3:0] FUN_CMP_LT = 4'b1100;
    localparam logic [3:0] FUN_SHR    = 4'b1101;
    localparam logic [3:0] FUN_SHL    = 4'b1110;
    localparam logic [3:0] FUN_NOP    = 4'b1111;

    // Flag vector order: {Arith, Logic, Cmp, Shift}
    localparam int FLAG_ARITH = 3;
    localparam int FLAG_LOGIC = 2;
    localparam int FLAG_CMP   = 1;
    localparam int FLAG_SHIFT = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_t;

    // Class flag the ALU raises for a given opcode; NOP raises none.
    function automatic logic [3:0] expected_flags(input logic [3:0] fun);
        logic [3:0] f;
        f = 4'b0000;
        if (fun <= FUN_DIV)
            f[FLAG_ARITH] = 1'b1;
        else if (fun <= FUN_XNOR)
            f[FLAG_LOGIC] = 1'b1;
        else if (fun <= FUN_CMP_LT)
            f[FLAG_CMP] = 1'b1;
        else if (fun <= FUN_SHL)
            f[FLAG_SHIFT] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_checker.sv
// Combinational check of ALU class flags against the opcode that produced them.
// Ports:
//   i_fun   [3:0]  opcode that was executed
//   i_flags [3:0]  {Arith, Logic, Cmp, Shift} flags returned by the ALU
//   o_err          1 when the flags differ from the opcode's class
module alu_flag_checker
    import alu_pkg::*;
(
    input  logic [3:0] i_fun,
    input  logic [3:0] i_flags,
    output logic       o_err
);

    logic [3:0] w_exp;

    assign w_exp = expected_flags(i_fun);
    assign o_err = (i_flags != w_exp);

endmodule

// File: rtl/alu_sequencer.sv
// Command-side initiator for the registered ALU. Takes one operation per
// CMD handshake, drives it into the ALU for a single cycle, captures the
// registered result and class flags, checks the flags and returns
// result/flags/error on the RSP handshake.
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY           command handshake
//   CMD_FUN, CMD_A, CMD_B         opcode and operands
//   ALU_A, ALU_B, ALU_FUN         drive into the ALU
//   ALU_OUT, ALU_FLAGS            registered result and flags from the ALU
//   RSP_VALID/RSP_READY           response handshake
//   RSP_DATA, RSP_FLAGS, RSP_ERR  captured result, flags, error status
//   OP_COUNT                      number of responses consumed (wraps)
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [3:0]       CMD_FUN,
    input  logic [WIDTH-1:0] CMD_A,
    input  logic [WIDTH-1:0] CMD_B,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [3:0]       ALU_FUN,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic [3:0]       ALU_FLAGS,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic [3:0]       RSP_FLAGS,
    output logic             RSP_ERR,
    output logic [CNT_W-1:0] OP_COUNT
);

    seq_state_t       r_state;
    logic [3:0]       r_fun;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_fun;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_count;

    logic             w_flag_err;
    logic             w_div0;

    alu_flag_checker u_chk (
        .i_fun   (r_fun),
        .i_flags (ALU_FLAGS),
        .o_err   (w_flag_err)
    );

    assign w_div0    = (CMD_FUN == FUN_DIV) && (CMD_B == '0);
    assign CMD_READY = (r_state == ST_IDLE);

    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_FLAGS = r_rsp_flags;
    assign RSP_ERR   = r_rsp_err;
    assign OP_COUNT  = r_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_fun       <= FUN_NOP;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= FUN_NOP;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= 4'b0000;
            r_rsp_err   <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        r_fun <= CMD_FUN;
                        if (w_div0) begin
                            // Divide by zero is answered locally; the ALU
                            // operand registers keep their previous values.
                            r_rsp_data  <= '0;
                            r_rsp_flags <= 4'b0000;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_alu_a   <= CMD_A;
                            r_alu_b   <= CMD_B;
                            r_alu_fun <= CMD_FUN;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // ALU registers its result at this edge; park it on NOP.
                    r_alu_fun <= FUN_NOP;
                    r_state   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_rsp_data  <= ALU_OUT;
                    r_rsp_flags <= ALU_FLAGS;
                    r_rsp_err   <= w_flag_err;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_count     <= r_count + 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic [3:0]       cmd_fun;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic             rsp_ready;

    logic             cmd_ready, rsp_valid, rsp_err;
    logic [WIDTH-1:0] alu_a, alu_b, rsp_data;
    logic [3:0]       alu_fun, rsp_flags;
    logic [15:0]      op_count;

    logic             cmd_ready2, rsp_valid2, rsp_err2;
    logic [WIDTH-1:0] alu_a2, alu_b2, rsp_data2;
    logic [3:0]       alu_fun2, rsp_flags2;
    logic [1:0]       op_count2;

    logic [WIDTH-1:0] m_out;
    logic [3:0]       m_flags;
    logic             force_en;
    logic [3:0]       force_flags;
    logic             div_watch;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [3:0]       flags;
        logic             err;
    } exp_t;
    exp_t exp_q[$];

    alu_sequencer #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_FUN(cmd_fun), .CMD_A(cmd_a), .CMD_B(cmd_b),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
        .ALU_OUT(m_out), .ALU_FLAGS(m_flags),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_DATA(rsp_data), .RSP_FLAGS(rsp_flags), .RSP_ERR(rsp_err),
        .OP_COUNT(op_count)
    );

    // Narrow-counter instance; it runs in lockstep with dut, so it can share
    // the ALU model's outputs.
    alu_sequencer #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .CLK(clk), .RST(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready2),
        .CMD_FUN(cmd_fun), .CMD_A(cmd_a), .CMD_B(cmd_b),
        .ALU_A(alu_a2), .ALU_B(alu_b2), .ALU_FUN(alu_fun2),
        .ALU_OUT(m_out), .ALU_FLAGS(m_flags),
        .RSP_VALID(rsp_valid2), .RSP_READY(rsp_ready),
        .RSP_DATA(rsp_data2), .RSP_FLAGS(rsp_flags2), .RSP_ERR(rsp_err2),
        .OP_COUNT(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU model.
    always @(posedge clk) begin
        logic [WIDTH-1:0] o;
        logic [3:0] f;
        o = '0;
        f = 4'b0000;
        case (alu_fun)
            4'b0000: begin o = alu_a + alu_b; f = 4'b1000; end
            4'b0001: begin o = alu_a - alu_b; f = 4'b1000; end
            4'b0010: begin o = alu_a * alu_b; f = 4'b1000; end
            4'b0011: begin o = (alu_b != 0) ? alu_a / alu_b : '0; f = 4'b1000; end
            4'b0100: begin o = alu_a & alu_b; f = 4'b0100; end
            4'b0101: begin o = alu_a | alu_b; f = 4'b0100; end
            4'b0110: begin o = ~(alu_a & alu_b); f = 4'b0100; end
            4'b0111: begin o = ~(alu_a | alu_b); f = 4'b0100; end
            4'b1000: begin o = alu_a ^ alu_b; f = 4'b0100; end
            4'b1001: begin o = ~(alu_a ^ alu_b); f = 4'b0100; end
            4'b1010: begin o = (alu_a == alu_b) ? 16'd1 : 16'd0; f = 4'b0010; end
            4'b1011: begin o = (alu_a > alu_b) ? 16'd2 : 16'd0; f = 4'b0010; end
            4'b1100: begin o = (alu_a < alu_b) ? 16'd3 : 16'd0; f = 4'b0010; end
            4'b1101: begin o = alu_a >> 1; f = 4'b0001; end
            4'b1110: begin o = alu_a << 1; f = 4'b0001; end
            default: begin o = '0; f = 4'b0000; end
        endcase
        m_out   <= o;
        m_flags <= force_en ? force_flags : f;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per consumed response.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: response data %0h with no expectation", rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (div_watch) check("div0_alu_fun_nop", 32'(alu_fun), 32'hF);
    end

    // Drive one command, then measure latency until RSP_VALID is seen.
    task automatic send(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                        input bit push, input logic [15:0] ed, input logic [3:0] ef,
                        input logic ee, input int exp_lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        if (push) exp_q.push_back('{data: ed, flags: ef, err: ee});
        cmd_valid = 1'b1; cmd_fun = fun; cmd_a = a; cmd_b = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (exp_lat > 0) begin
            @(negedge clk);
            n = 1;
            while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
            check("latency", 32'(n), 32'(exp_lat));
        end
    endtask

    task automatic wait_consumed();
        int n;
        n = 0;
        while (rsp_valid && n < 30) begin @(negedge clk); n++; end
        check("consume_timeout", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cnt_before;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_fun = 4'hF; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b1; force_en = 1'b0; force_flags = 4'b0; div_watch = 1'b0;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_fun", 32'(alu_fun), 32'hF);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // ADD
        send(4'b0000, 16'h0003, 16'h0004, 1, 16'h0007, 4'b1000, 1'b0, 3);
        wait_consumed();
        check("add_op_count", 32'(op_count), 32'd1);

        // DIV by zero: local response, ALU never driven
        div_watch = 1'b1;
        send(4'b0011, 16'h0010, 16'h0000, 1, 16'h0000, 4'b0000, 1'b1, 1);
        wait_consumed();
        @(negedge clk);
        div_watch = 1'b0;
        check("div_op_count", 32'(op_count), 32'd2);

        // CMP_GT with consumer stall
        rsp_ready = 1'b0;
        send(4'b1011, 16'h0009, 16'h0002, 1, 16'h0002, 4'b0010, 1'b0, 3);
        cnt_before = op_count;
        for (int i = 0; i < 5; i++) begin
            check("stall_data", 32'(rsp_data), 32'h2);
            check("stall_flags", 32'(rsp_flags), 32'b0010);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_op_count", 32'(op_count), 32'(cnt_before));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_consumed();
        check("gt_op_count", 32'(op_count), 32'd3);

        // SHL with corrupted flags from the ALU
        force_en = 1'b1; force_flags = 4'b0100;
        send(4'b1110, 16'h0001, 16'h0000, 1, 16'h0002, 4'b0100, 1'b1, 3);
        wait_consumed();
        force_en = 1'b0;

        // NOP opcode
        send(4'b1111, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 4'b0000, 1'b0, 3);
        wait_consumed();
        check("nop_op_count", 32'(op_count), 32'd5);

        // Reset during ISSUE drops the command
        send(4'b0000, 16'h0100, 16'h0001, 0, 16'h0, 4'h0, 1'b0, 0);
        @(negedge clk);
        check("pre_rst_alu_fun", 32'(alu_fun), 32'h0);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_alu_fun", 32'(alu_fun), 32'hF);
        check("midrst_alu_a", 32'(alu_a), 32'd0);
        check("midrst_op_count", 32'(op_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Back-to-back XORs; narrow counter wraps
        for (int i = 0; i < 5; i++) begin
            logic [15:0] a;
            logic [1:0] exp_c [5];
            exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd0; exp_c[4] = 2'd1;
            a = 16'(i + 1);
            send(4'b1000, a, 16'h00FF, 1, a ^ 16'h00FF, 4'b0100, 1'b0, 3);
            wait_consumed();
            check("cnt2_op_count", 32'(op_count2), 32'(exp_c[i]));
        end
        check("cnt16_op_count", 32'(op_count), 32'd5);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
